// File: rtl/serial_debug_tx.sv
// Transmit-only 8N1 UART that sends a MSG_LEN-byte word, most-significant byte first.
// Outputs are registered and computed from the next state so tx/busy change on state edges.
module serial_debug_tx #(
  parameter int unsigned CLK_PER_BIT = 434,
  parameter int unsigned MSG_LEN     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   block,
  input  logic                   send,
  input  logic [8*MSG_LEN-1:0]   data,
  output logic                   busy,
  output logic                   tx
);

  localparam int unsigned CntW  = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int unsigned ByteW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned DataW = 8 * MSG_LEN;
  localparam logic [CntW-1:0]  CntLast  = CntW'(CLK_PER_BIT - 1);
  localparam logic [ByteW-1:0] ByteLast = ByteW'(MSG_LEN - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [ByteW-1:0]   byte_q, byte_d;
  logic [DataW-1:0]   shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               cnt_last;
  logic [7:0]         cur_byte;

  assign cnt_last = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;

    unique case (state_q)
      StIdle: begin
        if (!block && send) begin
          state_d = StStart;
          shreg_d = data;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      StStart: begin
        cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        if (cnt_last) state_d = StData;
      end
      StData: begin
        cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        if (cnt_last) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        if (cnt_last) begin
          if (byte_q == ByteLast) begin
            state_d = StIdle;
            byte_d  = '0;
          end else begin
            state_d = StStart;
            byte_d  = byte_q + 1'b1;
            shreg_d = shreg_q << 8;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The current byte always sits in the top 8 bits of the shift register.
  assign cur_byte = shreg_d[DataW-1 -: 8];

  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle) || block;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_serial_debug_tx.sv
// Directed bench for serial_debug_tx: checks every bit edge of whole messages against
// hand-derived 8N1 frames, plus reset, block and ignored-input behaviour.
module tb_serial_debug_tx;

  localparam int CLK = 434;

  logic        clk;
  logic        rst;
  logic        block;
  logic        send;
  logic [31:0] data;
  logic        busy;
  logic        tx;

  int n_checks = 0;
  int n_fail   = 0;

  serial_debug_tx #(
    .CLK_PER_BIT(CLK),
    .MSG_LEN    (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .block(block),
    .send (send),
    .data (data),
    .busy (busy),
    .tx   (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation exceeded 150000 cycles");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge in IDLE. Pulses send, then checks tx and busy at the first and last
  // cycle of every bit. act_kind 1 re-pulses send with new data, 2 raises block, at act_cyc.
  task automatic run_message(input logic [31:0] msg, input logic [31:0] expv, input int act_cyc,
                             input int act_kind, input logic end_busy, input string name);
    int   cyc;
    logic exp_bit;
    data = msg;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    cyc  = 0;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < 10; s++) begin
        for (int j = 0; j < CLK; j++) begin
          if (j == 0 || j == CLK - 1) begin
            if (s == 0)      exp_bit = 1'b0;
            else if (s == 9) exp_bit = 1'b1;
            else             exp_bit = expv[8 * (3 - b) + s - 1];
            n_checks++;
            if (tx !== exp_bit) begin
              n_fail++;
              $display("FAIL %s tx byte %0d slot %0d cyc %0d: got %b want %b",
                       name, b, s, j, tx, exp_bit);
            end
            n_checks++;
            if (busy !== 1'b1) begin
              n_fail++;
              $display("FAIL %s busy byte %0d slot %0d cyc %0d: got %b want 1",
                       name, b, s, j, busy);
            end
          end
          if (cyc == act_cyc && act_kind == 1) begin
            send = 1'b1;
            data = ~msg;
          end else if (cyc == act_cyc && act_kind == 2) begin
            block = 1'b1;
          end else begin
            send = 1'b0;
          end
          @(negedge clk);
          cyc++;
        end
      end
    end
    n_checks++;
    if (busy !== end_busy) begin
      n_fail++;
      $display("FAIL %s busy at end: got %b want %b", name, busy, end_busy);
    end
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++;
      $display("FAIL %s tx at end: got %b want 1", name, tx);
    end
  endtask

  task automatic test_reset();
    logic bad;
    rst   = 1'b0;
    block = 1'b1;
    send  = 1'b0;
    data  = '0;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got tx=%b busy=%b want tx=1 busy=0", tx, busy);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL block_latency: got busy=%b want 0 before first edge", busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL block_after_release: got tx=%b busy=%b want tx=1 busy=1", tx, busy);
    end
    data = 32'hA5A5_A5A5;
    send = 1'b1;
    bad  = 1'b0;
    for (int i = 0; i < 2 * CLK; i++) begin
      @(negedge clk);
      send = 1'b0;
      if (tx !== 1'b1 || busy !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL blocked_send: got disturbance=%b want 0", bad);
    end
    block = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL unblock: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic();
    run_message(32'h7F1F_0701, 32'h7F1F_0701, -1, 0, 1'b0, "basic");
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_idle: got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_ignored_inputs();
    logic bad;
    run_message(32'h0F17_3371, 32'h0F17_3371, 15 * CLK + 7, 1, 1'b0, "second");
    bad = 1'b0;
    for (int i = 0; i < 3 * CLK; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL no_queued_send: got activity=%b want 0", bad);
    end
  endtask

  task automatic test_reset_mid_and_block();
    data = 32'h7F1F_0701;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    // Land inside the start bit of byte 2, where tx is low.
    repeat (20 * CLK + 100 - 1) @(negedge clk);
    n_checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got tx=%b busy=%b want tx=0 busy=1", tx, busy);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    run_message(32'h7F1F_0701, 32'h7F1F_0701, 20 * CLK + 5, 2, 1'b1, "after_reset");
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL block_hold: got busy=%b want 1", busy);
    end
    block = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL block_drop_latency: got busy=%b want 1 before edge", busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL block_drop: got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignored_inputs();
    test_reset_mid_and_block();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_debug_tx.md
# serial_debug_tx

Transmit-only UART debug port that serializes a fixed-length multi-byte message onto a single `tx` line. It sits at the edge of the FPGA design, with `tx` wired to the host serial/USB bridge. Any internal logic can use it to stream a status word to a terminal with a one-cycle `send` strobe. A `block` input holds the port off, for example while the host bridge is not ready.

## Interface
- `CLK_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200 baud).
- `MSG_LEN`, default 4: number of bytes per message; the data width is 8*MSG_LEN.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst`, input, 1: one clock; reset is asynchronous and active-low.
- `block`, input, 1: when high in IDLE, transmission is inhibited and `busy` is forced high.
- `send`, input, 1: single-cycle start strobe.
- `data`, input, 8*MSG_LEN: message; byte `data[8*MSG_LEN-1 -: 8]` is sent first.
- `busy`, output, 1: registered; high while blocked or transmitting.
- `tx`, output, 1: registered UART line; idles high.

## Operation
- **Serial format:** 8N1, one start bit (0), 8 data bits LSB first, one stop bit (1). There is no parity.
- **Byte order:** most-significant byte first, least-significant byte last.
- **State machine:** IDLE -> START -> DATA -> STOP.
  - From STOP, go to START if bytes remain; otherwise go to IDLE.
- **IDLE:**
  - `tx`=1.
  - If `block`=1: `busy`=1 and `send` is ignored.
  - If `block`=0 and `send`=0: `busy`=0.
  - If `block`=0 and `send`=1: latch all of `data` into a shift register, clear the byte and bit counters, and go to START.
- **Input capture:** `data` is sampled only on the accepted `send` edge. Later changes to `data` do not affect the message in flight.
- **`send` while not in IDLE:** ignored and not queued.
- **START:** `tx`=0 for CLK_PER_BIT cycles.
- **DATA:** `tx`=current byte bit[i], for i = 0..7, each held for CLK_PER_BIT cycles.
- **STOP:** `tx`=1 for CLK_PER_BIT cycles.
  - The byte counter advances.
  - If more bytes remain, the next START follows immediately with no inter-byte gap.
- **`block` during transmission:** no effect. The message always completes. If `block` is high on return to IDLE, `busy` stays high.
- **Counters:**
  - The bit-period counter is width clog2(CLK_PER_BIT) and counts 0..CLK_PER_BIT-1, then wraps.
  - The byte counter counts 0..MSG_LEN-1.
- **Reset values:**
  - Asserting `rst` low at any time, including mid-message, immediately forces `tx`=1, `busy`=0, state IDLE, and all counters to 0.
  - Any partial frame is abandoned.

## Timing
- **Start latency:** `send` accepted at edge N gives `tx`=0 and `busy`=1 after edge N. The start bit begins at N+1.
- **Message length:** exactly MSG_LEN*10*CLK_PER_BIT cycles from the start-bit edge to the return to IDLE. With defaults this is 17360 cycles (347.2 µs at 50 MHz).
- **End of message:** `busy` falls on the same edge that the final stop bit ends, provided `block`=0. A new `send` is accepted on the following cycle.
- **Bit boundaries:** each bit boundary is exactly CLK_PER_BIT cycles after the previous one, with no cumulative drift.
- **`block` response:** after reset release, `busy` follows `block` with one cycle of latency while in IDLE.

## Test plan
- **Reset and block:** `rst` low for 5 cycles with `block`=1 -> `tx`=1 and `busy`=0 during reset; `busy`=1 one cycle after release; `tx` stays 1; a `send` pulse produces no start bit.
- **Basic message:** `block`=0, `data`=0x7F1F0701, 1-cycle `send` -> bytes 0x7F, 0x1F, 0x07, 0x01 on `tx`, each as 8N1 LSB-first, 434 cycles/bit, no gaps. `busy` is high for exactly 17360 cycles, then 0.
- **Second message:** after idle, `data`=0x0F173371 and `send` -> bytes 0x0F, 0x17, 0x33, 0x71 decoded correctly.
- **Ignored inputs:** `send` re-pulsed and `data` changed mid-message -> the in-flight message is unchanged and no second message follows.
- **`block` mid-message:** `block` raised mid-message -> the message completes; `busy` stays 1 after the last stop bit; lowering `block` drops `busy` one cycle later.
- **Reset mid-message:** `rst` asserted during byte 2 -> `tx`=1 and `busy`=0 immediately. After release, a new `send` transmits the full message starting at byte 0.
